// File: rtl/n64_vinfo_tracker.sv
// N64 video-info tracker: derives {palmode,480i} from the sync stream, measures
// lines per field and filters mode changes over several agreeing fields.
module n64_vinfo_tracker #(
    parameter int unsigned LINE_CNT_W      = 10,
    parameter int unsigned PAL_LINE_THRESH = 288,
    parameter int unsigned STABLE_FRAMES   = 2
) (
    input  logic                  VCLK,
    input  logic                  nRST,
    input  logic                  nVDSYNC,
    input  logic [3:0]            Sync_pre,
    input  logic [3:0]            Sync_cur,
    output logic [1:0]            vinfo_o,
    output logic [LINE_CNT_W-1:0] lines_per_field_o,
    output logic                  field_id_o,
    output logic                  vinfo_valid_o,
    output logic                  newframe_o,
    output logic                  mode_change_o
);

    localparam int unsigned           STAB_W   = $clog2(STABLE_FRAMES + 1);
    localparam logic [STAB_W-1:0]     STAB_TGT = STAB_W'(STABLE_FRAMES);
    localparam logic [LINE_CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LINE_CNT_W-1:0] r_line_cnt;
    logic [LINE_CNT_W-1:0] r_lines;
    logic                  r_field_id;
    logic                  r_prev_field_id;
    logic [STAB_W-1:0]     r_stab_cnt;
    logic [1:0]            r_stored_cand;
    logic [1:0]            r_vinfo;
    logic                  r_valid;
    logic                  r_newframe;
    logic                  r_mode_change;

    logic                  w_act;
    logic                  w_vs_pos;
    logic                  w_vs_neg;
    logic                  w_hs_pos;
    logic                  w_hs_neg;
    logic                  w_cnt_sat;
    logic                  w_cand_pal;
    logic                  w_cand_480i;
    logic [1:0]            w_cand;
    logic [STAB_W-1:0]     w_stab_inc;
    logic [STAB_W-1:0]     w_stab_tmp;
    logic [STAB_W-1:0]     w_stab_nxt;
    logic [1:0]            w_stored_nxt;
    logic [1:0]            w_vinfo_nxt;
    logic                  w_valid_nxt;
    logic                  w_mode_chg;
    logic                  w_unused_sync;

    assign w_act    = ~nVDSYNC;
    assign w_vs_pos = w_act & ~Sync_pre[3] &  Sync_cur[3];
    assign w_vs_neg = w_act &  Sync_pre[3] & ~Sync_cur[3];
    assign w_hs_pos = w_act & ~Sync_pre[1] &  Sync_cur[1];
    assign w_hs_neg = w_act &  Sync_pre[1] & ~Sync_cur[1];

    assign w_unused_sync = ^{Sync_pre[2], Sync_pre[0], Sync_cur[2], Sync_cur[0]};

    assign w_cnt_sat  = (r_line_cnt == CNT_MAX);
    assign w_cand_pal = (32'(r_line_cnt) >= PAL_LINE_THRESH);
    // Interlace candidate: the field ID just latched differs from the one before it.
    assign w_cand_480i = r_field_id ^ r_prev_field_id;
    assign w_cand      = {w_cand_pal, w_cand_480i};
    assign w_stab_inc  = (r_stab_cnt == STAB_TGT) ? r_stab_cnt : r_stab_cnt + STAB_W'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_stab_nxt   = r_stab_cnt;
        w_stored_nxt = r_stored_cand;
        w_vinfo_nxt  = r_vinfo;
        w_valid_nxt  = r_valid;
        w_mode_chg   = 1'b0;
        w_stab_tmp   = '0;
        if (w_vs_pos) begin
            case (r_state)
                ST_INIT: begin
                    w_stab_nxt  = '0;
                    w_state_nxt = ST_ACQUIRE;
                end
                ST_ACQUIRE, ST_LOCKED: begin
                    if (w_cnt_sat) begin
                        w_valid_nxt = 1'b0;
                        w_stab_nxt  = '0;
                        w_state_nxt = ST_ACQUIRE;
                    end else if (r_state == ST_LOCKED && w_cand == r_vinfo) begin
                        w_stab_nxt = '0;
                    end else begin
                        if (w_cand == r_stored_cand) begin
                            w_stab_tmp = w_stab_inc;
                        end else begin
                            w_stored_nxt = w_cand;
                            w_stab_tmp   = STAB_W'(1);
                        end
                        if (w_stab_tmp == STAB_TGT) begin
                            w_vinfo_nxt = w_cand;
                            w_stab_nxt  = '0;
                            if (r_state == ST_LOCKED) begin
                                w_mode_chg = 1'b1;
                            end else begin
                                w_valid_nxt = 1'b1;
                                w_state_nxt = ST_LOCKED;
                            end
                        end else begin
                            w_stab_nxt = w_stab_tmp;
                        end
                    end
                end
                default: w_state_nxt = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            r_state         <= ST_INIT;
            r_line_cnt      <= '0;
            r_lines         <= '0;
            r_field_id      <= 1'b0;
            r_prev_field_id <= 1'b0;
            r_stab_cnt      <= '0;
            r_stored_cand   <= '0;
            r_vinfo         <= 2'b01;
            r_valid         <= 1'b0;
            r_newframe      <= 1'b0;
            r_mode_change   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_stab_cnt    <= w_stab_nxt;
            r_stored_cand <= w_stored_nxt;
            r_vinfo       <= w_vinfo_nxt;
            r_valid       <= w_valid_nxt;
            r_newframe    <= w_vs_pos;
            r_mode_change <= w_mode_chg;
            // A vsync rise swallows a coincident hsync rise.
            if (w_vs_pos) begin
                r_lines    <= r_line_cnt;
                r_line_cnt <= '0;
            end else if (w_hs_pos && !w_cnt_sat) begin
                r_line_cnt <= r_line_cnt + LINE_CNT_W'(1);
            end
            if (w_vs_neg) begin
                r_prev_field_id <= r_field_id;
                r_field_id      <= w_hs_neg;
            end
        end
    end

    assign vinfo_o           = r_vinfo;
    assign lines_per_field_o = r_lines;
    assign field_id_o        = r_field_id;
    assign vinfo_valid_o     = r_valid;
    assign newframe_o        = r_newframe;
    assign mode_change_o     = r_mode_change;

endmodule

// File: tb/tb_n64_vinfo_tracker.sv
// Directed bench for n64_vinfo_tracker: drives synthetic sync streams field by
// field and checks mode acquisition, filtering, saturation and reset behaviour.
module tb_n64_vinfo_tracker;

    logic       VCLK = 1'b0;
    logic       nRST = 1'b0;
    logic       nVDSYNC = 1'b0;
    logic [3:0] Sync_pre;
    logic [3:0] Sync_cur;
    logic [1:0] vinfo_o;
    logic [9:0] lines_per_field_o;
    logic       field_id_o;
    logic       vinfo_valid_o;
    logic       newframe_o;
    logic       mode_change_o;

    int checks = 0;
    int errors = 0;
    int nf_cnt = 0;
    int mc_cnt = 0;
    int nf0;
    int mc0;
    logic cur_vs = 1'b1;
    logic cur_hs = 1'b1;

    n64_vinfo_tracker #(
        .LINE_CNT_W(10),
        .PAL_LINE_THRESH(288),
        .STABLE_FRAMES(2)
    ) dut (
        .VCLK(VCLK),
        .nRST(nRST),
        .nVDSYNC(nVDSYNC),
        .Sync_pre(Sync_pre),
        .Sync_cur(Sync_cur),
        .vinfo_o(vinfo_o),
        .lines_per_field_o(lines_per_field_o),
        .field_id_o(field_id_o),
        .vinfo_valid_o(vinfo_valid_o),
        .newframe_o(newframe_o),
        .mode_change_o(mode_change_o)
    );

    always #5 VCLK = ~VCLK;

    always @(negedge VCLK) begin
        if (newframe_o === 1'b1) nf_cnt++;
        if (mode_change_o === 1'b1) mc_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic vs, input logic hs);
        Sync_pre = {cur_vs, 1'b0, cur_hs, 1'b0};
        Sync_cur = {vs, 1'b0, hs, 1'b0};
        cur_vs = vs;
        cur_hs = hs;
        @(posedge VCLK);
        #1;
    endtask

    task automatic line();
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
    endtask

    // n hsync rises between vsync rises; odd puts the hsync fall on the vsync fall.
    task automatic field(input int n, input logic odd);
        for (int i = 0; i < n - 1; i++) line();
        if (odd) begin
            step(1'b0, 1'b0);
        end else begin
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
        end
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        nVDSYNC = 1'b0;
        cur_vs = 1'b1;
        cur_hs = 1'b1;
        Sync_pre = 4'b1010;
        Sync_cur = 4'b1010;
        repeat (3) @(posedge VCLK);
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_vinfo", vinfo_o, 2'b01);
        chk("rst_lines", lines_per_field_o, 0);
        chk("rst_fid", field_id_o, 0);
        chk("rst_valid", vinfo_valid_o, 0);
        chk("rst_newframe", newframe_o, 0);
        chk("rst_modechg", mode_change_o, 0);

        // NTSC 240p acquisition
        nf0 = nf_cnt;
        field(263, 1'b0);
        field(263, 1'b0);
        chk("t1_valid_pre", vinfo_valid_o, 0);
        chk("t1_vinfo_pre", vinfo_o, 2'b01);
        field(263, 1'b0);
        chk("t1_vinfo", vinfo_o, 2'b00);
        chk("t1_valid", vinfo_valid_o, 1);
        chk("t1_lines", lines_per_field_o, 263);
        chk("t1_fid", field_id_o, 0);
        chk("t1_nf_hi", newframe_o, 1);
        step(1'b1, 1'b1);
        chk("t1_nf_lo", newframe_o, 0);
        chk("t1_nf_count", nf_cnt - nf0, 3);

        // single glitched PAL-length field is filtered
        mc0 = mc_cnt;
        field(312, 1'b0);
        chk("t3_vinfo_glitch", vinfo_o, 2'b00);
        chk("t3_lines_glitch", lines_per_field_o, 312);
        field(263, 1'b0);
        field(263, 1'b0);
        chk("t3_vinfo", vinfo_o, 2'b00);
        chk("t3_valid", vinfo_valid_o, 1);
        chk("t3_no_modechg", mc_cnt - mc0, 0);

        // switch to PAL 240p
        field(312, 1'b0);
        chk("t4_vinfo_1st", vinfo_o, 2'b00);
        chk("t4_mc_1st", mode_change_o, 0);
        field(312, 1'b0);
        chk("t4_vinfo", vinfo_o, 2'b10);
        chk("t4_mc_hi", mode_change_o, 1);
        chk("t4_valid", vinfo_valid_o, 1);
        step(1'b1, 1'b1);
        chk("t4_mc_lo", mode_change_o, 0);
        chk("t4_mc_count", mc_cnt - mc0, 1);

        // coincident hsync/vsync rise: the final hsync is not counted
        for (int i = 0; i < 300; i++) line();
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        chk("t4_same_lines", lines_per_field_o, 300);
        chk("t4_same_vinfo", vinfo_o, 2'b10);
        step(1'b1, 1'b1);

        // qualifier held high: nothing moves
        nf0 = nf_cnt;
        nVDSYNC = 1'b1;
        field(5, 1'b1);
        step(1'b1, 1'b1);
        chk("t5_dis_lines", lines_per_field_o, 300);
        chk("t5_dis_fid", field_id_o, 0);
        chk("t5_dis_vinfo", vinfo_o, 2'b10);
        chk("t5_dis_valid", vinfo_valid_o, 1);
        chk("t5_dis_nf", nf_cnt - nf0, 0);
        nVDSYNC = 1'b0;
        field(312, 1'b0);
        chk("t5_after_lines", lines_per_field_o, 312);
        step(1'b1, 1'b1);

        // counter saturation drops lock, then reacquire from ACQUIRE
        mc0 = mc_cnt;
        field(1100, 1'b0);
        chk("t5_sat_lines", lines_per_field_o, 10'h3ff);
        chk("t5_sat_valid", vinfo_valid_o, 0);
        chk("t5_sat_vinfo", vinfo_o, 2'b10);
        field(263, 1'b0);
        chk("t5_reacq_valid_pre", vinfo_valid_o, 0);
        field(263, 1'b0);
        chk("t5_reacq_valid", vinfo_valid_o, 1);
        chk("t5_reacq_vinfo", vinfo_o, 2'b00);
        step(1'b1, 1'b1);
        chk("t5_reacq_no_mc", mc_cnt - mc0, 0);

        // PAL 480i
        do_reset();
        mc0 = mc_cnt;
        field(312, 1'b1);
        field(313, 1'b0);
        chk("t2_valid_pre", vinfo_valid_o, 0);
        field(312, 1'b1);
        chk("t2_vinfo", vinfo_o, 2'b11);
        chk("t2_valid", vinfo_valid_o, 1);
        chk("t2_fid_odd", field_id_o, 1);
        field(313, 1'b0);
        chk("t2_fid_even", field_id_o, 0);
        chk("t2_lines", lines_per_field_o, 313);
        chk("t2_vinfo_hold", vinfo_o, 2'b11);
        field(312, 1'b1);
        chk("t2_fid_odd2", field_id_o, 1);
        step(1'b1, 1'b1);
        chk("t2_no_mc", mc_cnt - mc0, 0);

        // asynchronous reset mid-field while locked
        for (int i = 0; i < 50; i++) line();
        #2;
        nRST = 1'b0;
        #1;
        chk("t6_vinfo", vinfo_o, 2'b01);
        chk("t6_lines", lines_per_field_o, 0);
        chk("t6_fid", field_id_o, 0);
        chk("t6_valid", vinfo_valid_o, 0);
        chk("t6_nf", newframe_o, 0);
        chk("t6_mc", mode_change_o, 0);
        Sync_pre = Sync_cur;
        repeat (2) @(posedge VCLK);
        #1;
        nRST = 1'b1;
        mc0 = mc_cnt;
        for (int i = 0; i < 200; i++) line();
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("t6_init_lines", lines_per_field_o, 201);
        chk("t6_init_valid", vinfo_valid_o, 0);
        chk("t6_init_vinfo", vinfo_o, 2'b01);
        field(263, 1'b0);
        chk("t6_acq1_valid", vinfo_valid_o, 0);
        field(263, 1'b0);
        chk("t6_acq2_valid", vinfo_valid_o, 1);
        chk("t6_acq2_vinfo", vinfo_o, 2'b00);
        step(1'b1, 1'b1);
        chk("t6_no_mc", mc_cnt - mc0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
